// File: rtl/cache_pkg.sv
// Shared types for the line write buffer: controller states and the default cache line type.
package cache_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned LINE_ADDR_LEN_DEF = 3;
    localparam int unsigned LINE_W_DEF        = WORD_W << LINE_ADDR_LEN_DEF;

    // Line type for the default geometry; other geometries size their ports from WORD_W.
    typedef logic [LINE_W_DEF-1:0] line_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFetch,
        StResp
    } wb_state_e;

endpackage

// File: rtl/line_fifo.sv
// Entry storage for the write buffer: FIFO of {addr, line} with in-place overwrite and a
// parallel address compare that reports the youngest matching valid entry.
module line_fifo #(
    parameter int unsigned DEPTH_LEN = 2,
    parameter int unsigned ADDR_LEN  = 9,
    parameter int unsigned LINE_W    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [ADDR_LEN-1:0]  i_push_addr,
    input  logic [LINE_W-1:0]    i_push_line,
    input  logic                 i_pop,
    input  logic                 i_ovr,
    input  logic [DEPTH_LEN-1:0] i_ovr_idx,
    input  logic [LINE_W-1:0]    i_ovr_line,
    input  logic [ADDR_LEN-1:0]  i_cmp_addr,
    output logic                 o_hit,
    output logic [DEPTH_LEN-1:0] o_hit_idx,
    output logic [LINE_W-1:0]    o_hit_line,
    output logic [ADDR_LEN-1:0]  o_head_addr,
    output logic [LINE_W-1:0]    o_head_line,
    output logic [DEPTH_LEN:0]   o_occupancy,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned Depth = 1 << DEPTH_LEN;

    logic [ADDR_LEN-1:0]  r_addr [Depth];
    logic [LINE_W-1:0]    r_line [Depth];
    logic [Depth-1:0]     r_valid;
    logic [DEPTH_LEN-1:0] r_wr_ptr;
    logic [DEPTH_LEN-1:0] r_rd_ptr;
    logic [DEPTH_LEN:0]   r_count;

    logic                 w_do_push;
    logic                 w_do_pop;
    logic [DEPTH_LEN-1:0] w_scan_idx;

    assign o_full      = (r_count == (DEPTH_LEN+1)'(Depth));
    assign o_empty     = (r_count == '0);
    assign o_occupancy = r_count;
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_addr[i] <= '0;
                r_line[i] <= '0;
            end
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_addr[r_wr_ptr]  <= i_push_addr;
                r_line[r_wr_ptr]  <= i_push_line;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + DEPTH_LEN'(1);
            end
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + DEPTH_LEN'(1);
            end
            if (i_ovr) begin
                r_line[i_ovr_idx] <= i_ovr_line;
            end
            r_count <= r_count + (DEPTH_LEN+1)'(w_do_push) - (DEPTH_LEN+1)'(w_do_pop);
        end
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        w_scan_idx = r_rd_ptr;
        for (int k = 0; k < Depth; k++) begin
            w_scan_idx = r_rd_ptr + DEPTH_LEN'(k);
            if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == i_cmp_addr)) begin
                o_hit     = 1'b1;
                o_hit_idx = w_scan_idx;
            end
        end
    end

    assign o_hit_line  = r_line[o_hit_idx];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_line = r_line[r_rd_ptr];

endmodule

// File: rtl/line_write_buffer.sv
// Write buffer between a cache and main memory: absorbs line writes, serves reads from
// buffered lines, and drains entries to memory oldest-first when the cache is quiet.
module line_write_buffer
    import cache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned ADDR_LEN      = 9,
    parameter int unsigned DEPTH_LEN     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_LEN-1:0]                  up_addr,
    input  logic                                 up_rd_req,
    input  logic                                 up_wr_req,
    input  logic [(WORD_W << LINE_ADDR_LEN)-1:0] up_wr_line,
    output logic [(WORD_W << LINE_ADDR_LEN)-1:0] up_rd_line,
    output logic                                 up_gnt,
    output logic [ADDR_LEN-1:0]                  mem_addr,
    output logic                                 mem_rd_req,
    output logic                                 mem_wr_req,
    output logic [(WORD_W << LINE_ADDR_LEN)-1:0] mem_wr_line,
    input  logic [(WORD_W << LINE_ADDR_LEN)-1:0] mem_rd_line,
    input  logic                                 mem_gnt,
    output logic [DEPTH_LEN:0]                   occupancy,
    output logic                                 full,
    output logic                                 empty
);

    localparam int unsigned LineW = WORD_W << LINE_ADDR_LEN;

    wb_state_e            r_state;
    wb_state_e            w_state_d;
    logic [LineW-1:0]     r_rd_line;
    logic [ADDR_LEN-1:0]  r_fetch_addr;

    logic                 w_hit;
    logic [DEPTH_LEN-1:0] w_hit_idx;
    logic [LineW-1:0]     w_hit_line;
    logic [ADDR_LEN-1:0]  w_head_addr;
    logic [LineW-1:0]     w_head_line;
    logic                 w_idle_wr;
    logic                 w_idle_rd;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovr;

    // A write outranks a simultaneous read.
    assign w_idle_wr = (r_state == StIdle) && up_wr_req;
    assign w_idle_rd = (r_state == StIdle) && !up_wr_req && up_rd_req;
    assign w_ovr     = w_idle_wr && w_hit;
    assign w_push    = w_idle_wr && !w_hit && !full;
    assign w_pop     = (r_state == StDrain) && mem_gnt;

    line_fifo #(
        .DEPTH_LEN (DEPTH_LEN),
        .ADDR_LEN  (ADDR_LEN),
        .LINE_W    (LineW)
    ) u_line_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (up_addr),
        .i_push_line (up_wr_line),
        .i_pop       (w_pop),
        .i_ovr       (w_ovr),
        .i_ovr_idx   (w_hit_idx),
        .i_ovr_line  (up_wr_line),
        .i_cmp_addr  (up_addr),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_hit_line  (w_hit_line),
        .o_head_addr (w_head_addr),
        .o_head_line (w_head_line),
        .o_occupancy (occupancy),
        .o_full      (full),
        .o_empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (up_wr_req) begin
                    // A write that finds the buffer full waits for one drain, then retries.
                    w_state_d = (w_hit || !full) ? StResp : StDrain;
                end else if (up_rd_req) begin
                    w_state_d = w_hit ? StResp : StFetch;
                end else if (!empty) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: if (mem_gnt) w_state_d = StIdle;
            StFetch: if (mem_gnt) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        up_gnt      = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        case (r_state)
            StDrain: begin
                mem_wr_req  = 1'b1;
                mem_addr    = w_head_addr;
                mem_wr_line = w_head_line;
            end
            StFetch: begin
                mem_rd_req = 1'b1;
                mem_addr   = r_fetch_addr;
            end
            StResp:  up_gnt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_line    <= '0;
            r_fetch_addr <= '0;
        end else begin
            if (w_idle_rd) begin
                if (w_hit) begin
                    r_rd_line <= w_hit_line;
                end else begin
                    r_fetch_addr <= up_addr;
                end
            end
            if ((r_state == StFetch) && mem_gnt) begin
                r_rd_line <= mem_rd_line;
            end
        end
    end

    assign up_rd_line = r_rd_line;

endmodule
